// File: rtl/div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : div_clk_monitor
// Purpose  : Receive-side checker for a divided clock or slow strobe. Measures
//            rise-to-rise period and high time in clk cycles, compares them
//            with expected values, and reports per-measurement results, lock
//            status, loss of signal and a saturating error count.
// Revision : 1.0 - initial release
// ============================================================================
module div_clk_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 4,
  parameter int EXP_HIGH   = 2,
  parameter int TIMEOUT    = 64,
  parameter int LOCK_N     = 4,
  parameter int SYNC_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             mismatch,
  output logic             locked,
  output logic             lost,
  output logic [7:0]       err_cnt
);

  localparam int                GOOD_W       = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  C_EXP_PERIOD = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  C_EXP_HIGH   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]  C_TIMEOUT    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);
  localparam logic [GOOD_W-1:0] C_LOCK_LAST  = GOOD_W'(LOCK_N - 1);
  localparam logic [GOOD_W-1:0] C_LOCK_N     = GOOD_W'(LOCK_N);
  localparam logic [GOOD_W-1:0] C_GOOD_ONE   = GOOD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_LOST = 2'd2
  } state_t;

  state_t            state_q;
  logic              s;
  logic              s_d_q;
  logic              rise;
  logic [CNT_W-1:0]  per_cnt_q;
  logic [CNT_W-1:0]  hi_cnt_q;
  logic [CNT_W-1:0]  cap_per_q;
  logic [CNT_W-1:0]  cap_hi_q;
  logic              meas_pend_q;
  logic              to_pend_q;
  logic [GOOD_W-1:0] good_q;
  logic [CNT_W-1:0]  per_inc_d;
  logic [CNT_W-1:0]  hi_inc_d;
  logic [7:0]        err_inc_d;
  logic              cap_bad_d;

  // Optional two-flop synchroniser in front of the edge detector
  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [1:0] sync_q;
      // Shift sig_in through two flops into the clk domain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], sig_in};
      end
      assign s = sync_q[1];
    end else begin : g_nosync
      assign s = sig_in;
    end
  endgenerate

  // Delayed copy of the sampled input for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_d_q <= 1'b0;
    else     s_d_q <= s;
  end

  assign rise      = s & ~s_d_q;
  assign per_inc_d = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + C_CNT_ONE;
  assign hi_inc_d  = (hi_cnt_q  == '1) ? hi_cnt_q  : hi_cnt_q  + C_CNT_ONE;
  assign err_inc_d = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  assign cap_bad_d = (cap_per_q != C_EXP_PERIOD) || (cap_hi_q != C_EXP_HIGH);

  // Measurement FSM: counters, capture, result publication, lock and error tracking.
  // A capture made on a rise cycle is published one cycle later; a timeout seen
  // on a non-rise cycle is likewise reported one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      cap_per_q   <= '0;
      cap_hi_q    <= '0;
      meas_pend_q <= 1'b0;
      to_pend_q   <= 1'b0;
      good_q      <= '0;
      meas_valid  <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      mismatch    <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      meas_valid  <= 1'b0;
      meas_pend_q <= 1'b0;
      to_pend_q   <= 1'b0;

      if (meas_pend_q) begin
        meas_valid <= 1'b1;
        period_out <= cap_per_q;
        high_out   <= cap_hi_q;
        mismatch   <= cap_bad_d;
        if (cap_bad_d) begin
          good_q  <= '0;
          locked  <= 1'b0;
          err_cnt <= err_inc_d;
        end else if (good_q >= C_LOCK_LAST) begin
          good_q <= C_LOCK_N;
          locked <= 1'b1;
        end else begin
          good_q <= good_q + C_GOOD_ONE;
        end
      end

      if (to_pend_q) begin
        lost    <= 1'b1;
        locked  <= 1'b0;
        good_q  <= '0;
        err_cnt <= err_inc_d;
      end

      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q   <= ST_MEAS;
            per_cnt_q <= C_CNT_ONE;
            hi_cnt_q  <= C_CNT_ONE;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            cap_per_q   <= per_cnt_q;
            cap_hi_q    <= hi_cnt_q;
            meas_pend_q <= 1'b1;
            per_cnt_q   <= C_CNT_ONE;
            hi_cnt_q    <= C_CNT_ONE;
          end else begin
            if (per_cnt_q == C_TIMEOUT) begin
              state_q   <= ST_LOST;
              to_pend_q <= 1'b1;
            end
            per_cnt_q <= per_inc_d;
            if (s) hi_cnt_q <= hi_inc_d;
          end
        end
        ST_LOST: begin
          // First edge after a loss only re-arms the measurement
          if (rise) begin
            state_q   <= ST_MEAS;
            lost      <= 1'b0;
            per_cnt_q <= C_CNT_ONE;
            hi_cnt_q  <= C_CNT_ONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
